// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS main control FSM with memory wait states,
//               illegal-opcode flag and retired-instruction counter.
//               Optional macro MC_ADDI_EN adds the ADDI execute/writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter int         CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             RegWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             ALUSrcA,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] c_FETCH  = 4'd0;
   localparam logic [3:0] c_DECODE = 4'd1;
   localparam logic [3:0] c_MEMADR = 4'd2;
   localparam logic [3:0] c_MEMRD  = 4'd3;
   localparam logic [3:0] c_MEMWB  = 4'd4;
   localparam logic [3:0] c_MEMWR  = 4'd5;
   localparam logic [3:0] c_EXEC   = 4'd6;
   localparam logic [3:0] c_RWB    = 4'd7;
   localparam logic [3:0] c_BRANCH = 4'd8;
   localparam logic [3:0] c_JUMP   = 4'd9;
   localparam logic [3:0] c_ADDIEX = 4'd10;
   localparam logic [3:0] c_ADDIWB = 4'd11;

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       r_state;
   logic [3:0]       w_next;
   logic             w_retire;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_FETCH;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire)
            r_count <= r_count + c_CNT_ONE;
      end
   end

   always_comb begin
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      RegWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      ALUSrcA     = 1'b0;
      illegal_op  = 1'b0;
      w_retire    = 1'b0;
      w_next      = c_FETCH;
      case (r_state)
         c_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            w_next  = mem_ready ? c_DECODE : c_FETCH;
         end
         c_DECODE: begin
            ALUSrcB = 2'b11;
            if (opcode == OP_LW || opcode == OP_SW)
               w_next = c_MEMADR;
            else if (opcode == OP_RTYPE)
               w_next = c_EXEC;
            else if (opcode == OP_BEQ)
               w_next = c_BRANCH;
            else if (opcode == OP_J)
               w_next = c_JUMP;
`ifdef MC_ADDI_EN
            else if (opcode == OP_ADDI)
               w_next = c_ADDIEX;
`endif
            else
               illegal_op = 1'b1;
         end
         c_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (opcode == OP_LW)
               w_next = c_MEMRD;
            else if (opcode == OP_SW)
               w_next = c_MEMWR;
         end
         c_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            w_next  = mem_ready ? c_MEMWB : c_MEMRD;
         end
         c_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            w_retire = 1'b1;
         end
         c_MEMWR: begin
            // MemWrite stays asserted for the whole wait so the store is held
            MemWrite = 1'b1;
            IorD     = 1'b1;
            w_next   = mem_ready ? c_FETCH : c_MEMWR;
            w_retire = mem_ready;
         end
         c_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            w_next  = c_RWB;
         end
         c_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            w_retire = 1'b1;
         end
         c_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            w_retire    = 1'b1;
         end
         c_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            w_retire = 1'b1;
         end
`ifdef MC_ADDI_EN
         c_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            w_next  = c_ADDIWB;
         end
         c_ADDIWB: begin
            RegWrite = 1'b1;
            w_retire = 1'b1;
         end
`else
         c_ADDIEX, c_ADDIWB: begin
            // ADDI decodes as illegal here, so these codes only appear as
            // unreachable values; the opcode compare keeps OP_ADDI referenced
            illegal_op = 1'b0 & (opcode == OP_ADDI);
         end
`endif
         default: begin
            w_next = c_FETCH;
         end
      endcase
      // A reset cycle must never write anything, even mid-instruction
      if (reset) begin
         {ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
          IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA} = '0;
         illegal_op = 1'b0;
      end
   end

   assign state       = reset ? 4'd0 : r_state;
   assign instr_count = r_count;

endmodule

`default_nettype wire
